// File: rtl/apx_float_addsub_cfg.sv
// rtl/apx_float_addsub_cfg.sv - parametrised approximate IEEE-754 adder/subtractor
// Multi-cycle, one operation in flight; result mantissa LSBs below nab are rounded away.
module apx_float_addsub_cfg #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int NAB_W   = 5,
  parameter int NAB_MAX = 20,
  parameter int BT_RND  = 0,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic             input_op,
  input  logic [NAB_W-1:0] input_nab,
  input  logic [W-1:0]     input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [W-1:0]     output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 4;
  localparam int SW   = MAN_W + 5;
  localparam int ZW   = MAN_W + 1;
  localparam int ZW1  = MAN_W + 2;
  localparam int NW   = $clog2(MAN_W + 1) + 1;
  localparam logic signed [EW-1:0] E_MIN = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_MAX = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] JUMP  = EW'(MAN_W + 3);
  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    GET_A, GET_B, TRUNC, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t                 state;
  logic [W-1:0]           a, b, z;
  logic                   op_r;
  logic [NW-1:0]          n_r, n_clamp;
  logic                   a_s, b_s, z_s;
  logic signed [EW-1:0]   a_e, b_e, z_e;
  logic [MW-1:0]          a_m, b_m;
  logic [SW-1:0]          sum;
  logic [MAN_W:0]         z_m;
  logic                   guard, round_bit, sticky;

  always_comb begin
    n_clamp = NW'(input_nab);
    if (32'(input_nab) > NAB_MAX) n_clamp = NW'(NAB_MAX);
  end

  // Operand approximation: optional round-at-bit-n, then clear the n LSBs.
  logic [W-1:0] t_inc, t_lo, a_t, b_t;
  always_comb begin
    t_inc = W'(1) << n_r;
    t_lo  = t_inc - W'(1);
    a_t   = a;
    b_t   = b;
    if (BT_RND != 0 && n_r != '0) begin
      if (|(a & (t_inc >> 1))) a_t = a + t_inc;
      if (|(b & (t_inc >> 1))) b_t = b + t_inc;
    end
    a_t = a_t & ~t_lo;
    b_t = b_t & ~t_lo;
  end

  logic [EXP_W-1:0] a_ef, b_ef;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  always_comb begin
    a_ef   = a[W-2:MAN_W];
    b_ef   = b[W-2:MAN_W];
    a_nan  = (&a_ef) && (|a[MAN_W-1:0]);
    b_nan  = (&b_ef) && (|b[MAN_W-1:0]);
    a_inf  = (&a_ef) && !(|a[MAN_W-1:0]);
    b_inf  = (&b_ef) && !(|b[MAN_W-1:0]);
    a_zero = (a_ef == '0) && !(|a[MAN_W-1:0]);
    b_zero = (b_ef == '0) && !(|b[MAN_W-1:0]);
  end

  logic signed [EW-1:0] d_ab, d_ba;
  assign d_ab = a_e - b_e;
  assign d_ba = b_e - a_e;

  // Round-to-nearest-even with the rounding point moved up by n bits.
  logic [MW-1:0]  ext, r_gm;
  logic           r_up;
  logic [MAN_W:0] zm_lo;
  logic [ZW1-1:0] zm_rnd;
  always_comb begin
    ext    = {z_m, guard, round_bit, sticky};
    r_gm   = MW'(4) << n_r;
    r_up   = (|(ext & r_gm)) && ((|(ext & (r_gm - MW'(1)))) || (|(ext & (r_gm << 1))));
    zm_lo  = (ZW'(1) << n_r) - ZW'(1);
    zm_rnd = {1'b0, z_m & ~zm_lo} + (ZW1'(r_up) << n_r);
  end

  logic signed [EW-1:0] ze_b;
  logic [W-1:0]         pack_z;
  always_comb begin
    ze_b   = z_e + EW'(BIAS);
    pack_z = {z_s, ze_b[EXP_W-1:0], z_m[MAN_W-1:0]};
    if (z_e > E_MAX)
      pack_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (z_e == E_MIN && !z_m[MAN_W])
      pack_z = {z_s, {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
    end else begin
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            op_r        <= input_op;
            n_r         <= n_clamp;
            input_a_ack <= 1'b0;
            state       <= GET_B;
          end
        end
        GET_B: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
            state       <= TRUNC;
          end
        end
        TRUNC: begin
          a     <= a_t;
          b     <= b_t;
          state <= UNPACK;
        end
        UNPACK: begin
          a_m   <= {1'b0, a[MAN_W-1:0], 3'b000};
          b_m   <= {1'b0, b[MAN_W-1:0], 3'b000};
          a_e   <= $signed(EW'(a_ef)) - EW'(BIAS);
          b_e   <= $signed(EW'(b_ef)) - EW'(BIAS);
          a_s   <= a[W-1];
          b_s   <= b[W-1] ^ op_r;
          state <= SPECIAL;
        end
        SPECIAL: begin
          state <= PUT_Z;
          if (a_nan || b_nan)                 z <= QNAN;
          else if (a_inf && b_inf && a_s != b_s) z <= QNAN;
          else if (a_inf)                     z <= {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else if (b_inf)                     z <= {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else if (a_zero && b_zero)          z <= {a_s & b_s, {(W-1){1'b0}}};
          else if (a_zero)                    z <= {b_s, b[W-2:0]};
          else if (b_zero)                    z <= a;
          else begin
            if (a_ef == '0) a_e <= E_MIN; else a_m[MW-1] <= 1'b1;
            if (b_ef == '0) b_e <= E_MIN; else b_m[MW-1] <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (a_e > b_e) begin
            if (d_ab > JUMP) begin
              b_e <= a_e;
              b_m <= {{(MW-1){1'b0}}, |b_m};
            end else begin
              b_e <= b_e + E_ONE;
              b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
            end
          end else if (b_e > a_e) begin
            if (d_ba > JUMP) begin
              a_e <= b_e;
              a_m <= {{(MW-1){1'b0}}, |a_m};
            end else begin
              a_e <= a_e + E_ONE;
              a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
            end
          end else begin
            state <= ADD_0;
          end
        end
        ADD_0: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            sum <= {1'b0, a_m} + {1'b0, b_m};
            z_s <= a_s;
          end else if (a_m >= b_m) begin
            sum <= {1'b0, a_m} - {1'b0, b_m};
            z_s <= a_s;
          end else begin
            sum <= {1'b0, b_m} - {1'b0, a_m};
            z_s <= b_s;
          end
          state <= ADD_1;
        end
        ADD_1: begin
          // Exact cancellation skips normalisation, which would otherwise walk down to E_MIN.
          if (sum == '0) begin
            z_m       <= '0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            z_s       <= 1'b0;
            z_e       <= E_MIN;
            state     <= PACK;
          end else if (sum[SW-1]) begin
            z_m       <= sum[SW-1:4];
            guard     <= sum[3];
            round_bit <= sum[2];
            sticky    <= sum[1] | sum[0];
            z_e       <= z_e + E_ONE;
            state     <= NORM_1;
          end else begin
            z_m       <= sum[SW-2:3];
            guard     <= sum[2];
            round_bit <= sum[1];
            sticky    <= sum[0];
            state     <= NORM_1;
          end
        end
        NORM_1: begin
          if (!z_m[MAN_W] && z_e > E_MIN) begin
            z_e       <= z_e - E_ONE;
            z_m       <= {z_m[MAN_W-1:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
          end else begin
            state <= NORM_2;
          end
        end
        NORM_2: begin
          if (z_e < E_MIN) begin
            z_e       <= z_e + E_ONE;
            z_m       <= {1'b0, z_m[MAN_W:1]};
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (zm_rnd[ZW1-1]) begin
            z_m <= {1'b1, {MAN_W{1'b0}}};
            z_e <= z_e + E_ONE;
          end else begin
            z_m <= zm_rnd[MAN_W:0];
          end
          state <= PACK;
        end
        PACK: begin
          z     <= pack_z;
          state <= PUT_Z;
        end
        PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_apx_float_addsub_cfg.sv
// tb/tb_apx_float_addsub_cfg.sv - bench for apx_float_addsub_cfg (default single precision)
module tb_apx_float_addsub_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        input_op;
  logic [4:0]  input_nab;
  logic        output_z_stb, output_z_ack;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apx_float_addsub_cfg dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_op(input_op), .input_nab(input_nab),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int msb64(input longint v);
    for (int i = 63; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Exact sum of the truncated operands, then one RNE rounding to a quantum of 2^n ulp.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input int n_req);
    int n, ea, eb, e0, p, e_top, q, k, pr, e2;
    longint sa, sb, s, m, r, rem, half, sig;
    logic [31:0] at, bt, lo;
    logic sgn;
    n  = (n_req > 20) ? 20 : n_req;
    lo = (32'd1 << n) - 32'd1;
    at = a & ~lo;
    bt = b & ~lo;
    ea = int'(at[30:23]) - 150;
    eb = int'(bt[30:23]) - 150;
    e0 = (ea < eb) ? ea : eb;
    sa = longint'({1'b1, at[22:0]}) << (ea - e0);
    sb = longint'({1'b1, bt[22:0]}) << (eb - e0);
    if (at[31]) sa = -sa;
    if (bt[31] ^ op) sb = -sb;
    s = sa + sb;
    if (s == 0) return 32'h0000_0000;
    sgn   = (s < 0);
    m     = sgn ? -s : s;
    p     = msb64(m);
    e_top = p + e0;
    q     = ((e_top > -126) ? e_top : -126) - 23 + n;
    k     = q - e0;
    if (k <= 0) begin
      r = m << (-k);
    end else begin
      r    = m >> k;
      rem  = m & ((longint'(1) << k) - 1);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && r[0])) r = r + 1;
    end
    pr = msb64(r);
    e2 = pr + q;
    if (e2 > 127) return {sgn, 8'hFF, 23'h0};
    if (e2 < -126) begin
      sig = r << (q + 149);
      return {sgn, 8'h00, sig[22:0]};
    end
    sig = (pr > 23) ? (r >> (pr - 23)) : (r << (23 - pr));
    return {sgn, 8'(e2 + 127), sig[22:0]};
  endfunction

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                      input logic [4:0] nv);
    int cnt;
    input_a = av; input_op = opv; input_nab = nv; input_a_stb = 1'b1;
    cnt = 0;
    while (!input_a_ack && cnt < 50) begin @(negedge clk); cnt++; end
    @(posedge clk); #1 input_a_stb = 1'b0;
    input_b = bv; input_b_stb = 1'b1;
    cnt = 0;
    while (!input_b_ack && cnt < 50) begin @(negedge clk); cnt++; end
    @(posedge clk); #1 input_b_stb = 1'b0;
  endtask

  task automatic recv(output logic [31:0] zv);
    int cnt;
    cnt = 0;
    zv  = 'x;
    while (!output_z_stb && cnt < 400) begin @(negedge clk); cnt++; end
    if (output_z_stb) zv = output_z;
    output_z_ack = 1'b1;
    @(posedge clk); #1 output_z_ack = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic opv, input logic [4:0] nv, input logic [31:0] ev);
    logic [31:0] zv;
    send(av, bv, opv, nv);
    recv(zv);
    check32(tag, zv, ev);
  endtask

  initial begin
    logic [31:0] z0, av, bv, ev;
    logic        opv;
    logic [4:0]  nv;
    int          ae, be, cnt;

    rst = 1'b1;
    input_a = '0; input_b = '0; input_op = 1'b0; input_nab = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_a_ack", {31'b0, input_a_ack}, 32'd0);
    check32("rst_b_ack", {31'b0, input_b_ack}, 32'd0);
    check32("rst_z_stb", {31'b0, output_z_stb}, 32'd0);
    check32("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("a_ack_rise", {31'b0, input_a_ack}, 32'd1);

    do_op("t1_add",      32'h3F800000, 32'h40000000, 1'b0, 5'd0,  32'h40400000);
    do_op("t1_sub",      32'h3F800000, 32'h40000000, 1'b1, 5'd0,  32'hBF800000);
    do_op("t2_cancel",   32'h3F800000, 32'h3F800000, 1'b1, 5'd0,  32'h00000000);
    do_op("t2_inf_inf",  32'h7F800000, 32'hFF800000, 1'b0, 5'd0,  32'hFFC00000);
    do_op("t3_n20",      32'h3F800000, 32'h3F8FFFFF, 1'b0, 5'd20, 32'h40000000);
    do_op("t3_n31",      32'h3F800000, 32'h3F8FFFFF, 1'b0, 5'd31, 32'h40000000);
    do_op("t4_ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd0,  32'h7F800000);
    do_op("t4_denorm",   32'h00000001, 32'h00000001, 1'b0, 5'd0,  32'h00000002);
    do_op("nan_in",      32'h7FC00000, 32'h3F800000, 1'b0, 5'd0,  32'hFFC00000);
    do_op("a_zero_sub",  32'h00000000, 32'h3F800000, 1'b1, 5'd0,  32'hBF800000);
    do_op("neg_zeros",   32'h80000000, 32'h80000000, 1'b0, 5'd0,  32'h80000000);
    do_op("b_inf_sub",   32'h3F800000, 32'h7F800000, 1'b1, 5'd0,  32'hFF800000);
    do_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 5'd0,  32'h3F800000);
    do_op("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 5'd0,  32'h3F800002);
    do_op("far_jump",    32'h3F800000, 32'h2F800000, 1'b0, 5'd0,  32'h3F800000);

    // Back-pressure: result must be held while output_z_ack stays low.
    send(32'h3F800000, 32'h40000000, 1'b0, 5'd0);
    cnt = 0;
    while (!output_z_stb && cnt < 400) begin @(negedge clk); cnt++; end
    z0 = output_z;
    check32("t5_value", z0, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32($sformatf("t5_stb_%0d", i), {31'b0, output_z_stb}, 32'd1);
      check32($sformatf("t5_hold_%0d", i), output_z, z0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1 output_z_ack = 1'b0;
    @(negedge clk);
    check32("t5_stb_drop", {31'b0, output_z_stb}, 32'd0);
    @(negedge clk);
    check32("t5_get_a", {31'b0, input_a_ack}, 32'd1);

    // Reset in the middle of a 20-step alignment.
    send(32'h3F800000, 32'h35800000, 1'b0, 5'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check32("t6_a_ack", {31'b0, input_a_ack}, 32'd0);
    check32("t6_b_ack", {31'b0, input_b_ack}, 32'd0);
    check32("t6_z_stb", {31'b0, output_z_stb}, 32'd0);
    do_op("t6_after", 32'h3F800000, 32'h40000000, 1'b0, 5'd0, 32'h40400000);

    for (int i = 0; i < 150; i++) begin
      ae = int'($urandom_range(1, 254));
      be = ae + int'($urandom_range(0, 60)) - 30;
      if (be < 1) be = 1;
      if (be > 254) be = 254;
      av  = {1'($urandom), 8'(ae), 23'($urandom)};
      bv  = {1'($urandom), 8'(be), 23'($urandom)};
      opv = 1'($urandom);
      nv  = 5'($urandom);
      ev  = ref_add(av, bv, opv, int'(nv));
      do_op($sformatf("rand_%0d", i), av, bv, opv, nv, ev);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
